// File: rtl/div_pkg.sv
// Shared state encoding, constants and helpers for the sequential divider.
package div_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StFix  = 2'd2,
    StDone = 2'd3
  } div_state_e;

  localparam int unsigned MaxWidth = 64;

  // Exception result patterns, sliced down to WIDTH by the user.
  localparam logic [MaxWidth-1:0] DivZeroQuot = '1;
  localparam logic [MaxWidth-1:0] OvfRem      = '0;

  function automatic int unsigned clog2(int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  // Most-negative two's-complement value of a w-bit word.
  function automatic logic [MaxWidth-1:0] min_pattern(int unsigned w);
    return {{(MaxWidth-1){1'b0}}, 1'b1} << (w - 1);
  endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negation, used for operand magnitudes and result signs.
module div_sign_fix #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] result_o
);

  localparam logic [WIDTH-1:0] One = {{(WIDTH-1){1'b0}}, 1'b1};

  // -MIN wraps to MIN, whose unsigned reading is the correct magnitude.
  always_comb begin
    result_o = neg_i ? (~value_i + One) : value_i;
  end

endmodule

// File: rtl/seq_divider_param.sv
// Iterative radix-2 non-restoring divider with start/done handshake,
// signed/unsigned mode, remainder output and exception flags.
module seq_divider_param
  import div_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter bit          SIGNED_EN = 1'b1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] OP1,
  input  logic [WIDTH-1:0] OP2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int unsigned          CntW     = clog2(WIDTH);
  localparam logic [CntW-1:0]      CntInit  = CntW'(WIDTH - 1);
  localparam logic [MaxWidth-1:0]  MinFull  = min_pattern(WIDTH);
  localparam logic [WIDTH-1:0]     MinVal   = MinFull[WIDTH-1:0];

  div_state_e state_q, state_d;

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;    // two's complement, MSB is the sign
  logic [WIDTH-1:0] quo_q, quo_d;    // dividend shifts out as quotient bits shift in
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d;
  logic [WIDTH-1:0] quotient_q, quotient_d, remainder_q, remainder_d;
  logic             dbz_q, dbz_d, ovf_q, ovf_d;

  logic             accept, sgn, op2_zero, sgn_ovf, exc;
  logic [WIDTH-1:0] op1_mag, op2_mag, quo_fix, rem_fix, rem_corr;
  logic [WIDTH:0]   rem_shift, rem_step, dvsr_ext;

  assign sgn      = SIGNED_EN && signed_mode;
  assign accept   = start && ((state_q == StIdle) || (state_q == StDone));
  assign op2_zero = (OP2 == '0);
  assign sgn_ovf  = sgn && (OP1 == MinVal) && (OP2 == '1);
  assign exc      = op2_zero || sgn_ovf;

  div_sign_fix #(.WIDTH(WIDTH)) u_op1_mag (
    .value_i  (OP1),
    .neg_i    (sgn & OP1[WIDTH-1]),
    .result_o (op1_mag)
  );

  div_sign_fix #(.WIDTH(WIDTH)) u_op2_mag (
    .value_i  (OP2),
    .neg_i    (sgn & OP2[WIDTH-1]),
    .result_o (op2_mag)
  );

  div_sign_fix #(.WIDTH(WIDTH)) u_quo_fix (
    .value_i  (quo_q),
    .neg_i    (qneg_q),
    .result_o (quo_fix)
  );

  div_sign_fix #(.WIDTH(WIDTH)) u_rem_fix (
    .value_i  (rem_corr),
    .neg_i    (rneg_q),
    .result_o (rem_fix)
  );

  // One non-restoring step: subtract when the partial remainder is
  // non-negative, add otherwise; the new sign yields the quotient bit.
  always_comb begin
    dvsr_ext  = {1'b0, dvsr_q};
    rem_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    rem_step  = rem_q[WIDTH] ? (rem_shift + dvsr_ext) : (rem_shift - dvsr_ext);
    rem_corr  = rem_q[WIDTH] ? (rem_q[WIDTH-1:0] + dvsr_q) : rem_q[WIDTH-1:0];
  end

  always_ff @(posedge CLK) begin
    if (!nRST) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = exc ? StDone : StCalc;
      StCalc:  if (cnt_q == '0) state_d = StFix;
      StFix:   state_d = StDone;
      StDone:  state_d = start ? (exc ? StDone : StCalc) : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q == StCalc) || (state_q == StFix);
    done = (state_q == StDone);
  end

  always_comb begin
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvsr_d      = dvsr_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;
    if (accept) begin
      cnt_d  = CntInit;
      rem_d  = '0;
      quo_d  = op1_mag;
      dvsr_d = op2_mag;
      qneg_d = sgn & (OP1[WIDTH-1] ^ OP2[WIDTH-1]);
      rneg_d = sgn & OP1[WIDTH-1];
      if (op2_zero) begin
        quotient_d  = DivZeroQuot[WIDTH-1:0];
        remainder_d = OP1;
        dbz_d       = 1'b1;
        ovf_d       = 1'b0;
      end else if (sgn_ovf) begin
        quotient_d  = OP1;
        remainder_d = OvfRem[WIDTH-1:0];
        dbz_d       = 1'b0;
        ovf_d       = 1'b1;
      end
    end else if (state_q == StCalc) begin
      rem_d = rem_step;
      quo_d = {quo_q[WIDTH-2:0], ~rem_step[WIDTH]};
      if (cnt_q != '0) cnt_d = cnt_q - CntW'(1);
    end else if (state_q == StFix) begin
      quotient_d  = quo_fix;
      remainder_d = rem_fix;
      dbz_d       = 1'b0;
      ovf_d       = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvsr_q      <= dvsr_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule
